paddle_ctrl: RTL and testbench

- Produces one paddle's geometry (PaddleX, PaddleY, PaddleL, PaddleW). The ball module consumes this geometry for collision and deflection.
- Each frame, movement comes from the keyboard keycode, or from a ball-tracking AI when ai_en=1.
- Movement has momentum: step size ramps while a direction is held, and the paddle is clamped to the playfield.
- Two instances are used: left player and right player/AI.

---
 rtl/pong_pkg.sv | 27 ++
 rtl/paddle_step_ramp.sv | 49 ++++
 rtl/paddle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_paddle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong types: coordinates, keycodes, playfield bounds and paddle directions.
// Both paddle instances and the ball logic import this package.
package pong_pkg;

  typedef logic [9:0]         coord_t;
  typedef logic signed [10:0] pos_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  localparam int Y_MIN = 20;
  localparam int Y_MAX = 461;

  // IDLE doubles as the "no direction" value for key requests and AI decisions.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } paddle_dir_e;

  function automatic pos_t clamp_pos(input pos_t v, input pos_t lo, input pos_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/paddle_step_ramp.sv
// Momentum ramp for the paddle: step grows by one every ACCEL_FRAMES held frames
// up to STEP_MAX, and collapses back to STEP_MIN on release, new direction or wall contact.
module paddle_step_ramp #(
  parameter int STEP_MIN     = 2,
  parameter int STEP_MAX     = 8,
  parameter int ACCEL_FRAMES = 4,
  parameter int SW           = 4,
  parameter int HW           = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enter,
  input  logic          advance,
  input  logic          wall,
  output logic [SW-1:0] step,
  output logic [HW-1:0] hold_cnt
);

  localparam logic [SW-1:0] S_MIN = SW'(STEP_MIN);
  localparam logic [SW-1:0] S_MAX = SW'(STEP_MAX);
  localparam logic [HW-1:0] H_ACC = HW'(ACCEL_FRAMES);
  localparam logic [HW-1:0] H_ONE = HW'(1);

  logic [HW-1:0] hold_inc;

  assign hold_inc = hold_cnt + H_ONE;

  // Wall contact wins over a fresh entry so a move that lands on a bound restarts slow.
  always_ff @(posedge clk) begin
    if (reset || clear || wall) begin
      step     <= S_MIN;
      hold_cnt <= '0;
    end else if (enter) begin
      step     <= S_MIN;
      hold_cnt <= H_ONE;
    end else if (advance) begin
      if (hold_inc == H_ACC) begin
        hold_cnt <= '0;
        if (step < S_MAX) begin
          step <= step + 1'b1;
        end
      end else begin
        hold_cnt <= hold_inc;
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// One pong paddle: keyboard or ball-tracking AI movement with momentum, clamped
// to the playfield. Geometry outputs feed the ball collision logic.
//
//   state | meaning
//   ------+----------------------------------------------
//   IDLE  | no direction held; paddle stationary
//   UP    | moving towards smaller Y (subtract step)
//   DOWN  | moving towards larger Y (add step)
module paddle_ctrl #(
  parameter int         PADDLE_X     = 40,
  parameter int         Y_CENTER     = 240,
  parameter int         HALF_LEN     = 32,
  parameter int         HALF_W       = 4,
  parameter int         Y_MIN        = pong_pkg::Y_MIN,
  parameter int         Y_MAX        = pong_pkg::Y_MAX,
  parameter int         STEP_MIN     = 2,
  parameter int         STEP_MAX     = 8,
  parameter int         ACCEL_FRAMES = 4,
  parameter logic [7:0] KEY_UP       = pong_pkg::KEY_W,
  parameter logic [7:0] KEY_DOWN     = pong_pkg::KEY_S,
  parameter int         AI_DELAY     = 3,
  parameter int         DEADBAND     = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       ai_en,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic [9:0] PaddleX,
  output logic [9:0] PaddleY,
  output logic [9:0] PaddleL,
  output logic [9:0] PaddleW,
  output logic       at_limit
);

  import pong_pkg::*;

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int HW = $clog2(ACCEL_FRAMES + 1);
  localparam int CW = (AI_DELAY > 0) ? $clog2(AI_DELAY + 1) : 1;

  localparam pos_t            YTOP   = pos_t'(Y_MIN + HALF_LEN);
  localparam pos_t            YBOT   = pos_t'(Y_MAX - HALF_LEN);
  localparam pos_t            DB     = pos_t'(DEADBAND);
  localparam logic [SW-1:0]   S_MIN  = SW'(STEP_MIN);
  localparam logic [CW-1:0]   C_LAST = CW'(AI_DELAY);

  paddle_dir_e   state_q, state_d;
  paddle_dir_e   ai_dir_q, ai_dir_d;
  paddle_dir_e   dir_req, ai_pick;
  logic [CW-1:0] ai_cnt_q, ai_cnt_d;
  logic          ai_en_q, ai_toggle;
  coord_t        y_q, y_d;
  logic          at_limit_d;

  logic [SW-1:0] step, move;
  logic [HW-1:0] unused_hold_cnt;
  logic          ramp_clear, ramp_enter, ramp_advance, at_bound;
  pos_t          y_sum, y_clamped, ball_diff;

  logic          unused_ballx;
  assign unused_ballx = ^BallX;

  assign PaddleX = 10'(PADDLE_X);
  assign PaddleL = 10'(HALF_LEN);
  assign PaddleW = 10'(HALF_W);
  assign PaddleY = y_q;

  assign ai_toggle = ai_en ^ ai_en_q;

  paddle_step_ramp #(
    .STEP_MIN     (STEP_MIN),
    .STEP_MAX     (STEP_MAX),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .SW           (SW),
    .HW           (HW)
  ) u_ramp (
    .clk      (frame_clk),
    .reset    (Reset),
    .clear    (ramp_clear),
    .enter    (ramp_enter),
    .advance  (ramp_advance),
    .wall     (at_bound),
    .step     (step),
    .hold_cnt (unused_hold_cnt)
  );

  always_comb begin
    dir_req = IDLE;
    if (ai_en) begin
      dir_req = ai_dir_q;
    end else if (keycode == KEY_UP) begin
      dir_req = UP;
    end else if (keycode == KEY_DOWN) begin
      dir_req = DOWN;
    end
  end

  // Next state, move amount and clamp. A mode switch freezes the paddle for one frame.
  always_comb begin
    state_d      = state_q;
    ramp_clear   = 1'b0;
    ramp_enter   = 1'b0;
    ramp_advance = 1'b0;
    move         = '0;

    if (ai_toggle || dir_req == IDLE) begin
      state_d    = IDLE;
      ramp_clear = 1'b1;
    end else if (state_q == IDLE || dir_req != state_q) begin
      state_d    = dir_req;
      ramp_enter = 1'b1;
      move       = S_MIN;
    end else begin
      ramp_advance = 1'b1;
      move         = step;
    end

    y_sum = pos_t'(y_q) + pos_t'(move);
    if (state_d == UP) begin
      y_sum = pos_t'(y_q) - pos_t'(move);
    end

    y_clamped  = clamp_pos(y_sum, YTOP, YBOT);
    at_bound   = (y_clamped == YTOP) || (y_clamped == YBOT);
    y_d        = y_clamped[9:0];
    at_limit_d = at_bound;
  end

  always_comb begin
    ball_diff = pos_t'(BallY) - pos_t'(y_q);
    ai_pick   = DOWN;
    if (ball_diff <= DB && ball_diff >= -DB) begin
      ai_pick = IDLE;
    end else if (ball_diff[10]) begin
      ai_pick = UP;
    end

    ai_cnt_d = ai_cnt_q + 1'b1;
    ai_dir_d = ai_dir_q;
    if (ai_toggle) begin
      ai_cnt_d = '0;
      ai_dir_d = IDLE;
    end else if (ai_cnt_q == C_LAST) begin
      ai_cnt_d = '0;
      ai_dir_d = ai_pick;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      y_q      <= coord_t'(Y_CENTER);
      ai_cnt_q <= '0;
      ai_dir_q <= IDLE;
      ai_en_q  <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      ai_cnt_q <= ai_cnt_d;
      ai_dir_q <= ai_dir_d;
      ai_en_q  <= ai_en;
      at_limit <= at_limit_d;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed frames from the bring-up scenarios, then random
// key holds, AI toggles and resets, all compared against an integer paddle model.
module tb_paddle_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       ai_en;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] PaddleX, PaddleY, PaddleL, PaddleW;
  logic       at_limit;

  int checks   = 0;
  int failures = 0;

  // reference model state: direction as -1 (up), 0 (none), +1 (down)
  int m_y, m_dir, m_step, m_hold, m_aicnt, m_aidir, m_aien_q, m_lim;

  paddle_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .ai_en     (ai_en),
    .BallX     (BallX),
    .BallY     (BallY),
    .PaddleX   (PaddleX),
    .PaddleY   (PaddleY),
    .PaddleL   (PaddleL),
    .PaddleW   (PaddleW),
    .at_limit  (at_limit)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int at_wall(input int y);
    return (y == 52 || y == 429) ? 1 : 0;
  endfunction

  task automatic mdl(input logic rst, input logic [7:0] key, input logic aien, input int bally);
    int req, amt, diff, new_aidir;
    if (rst) begin
      m_y = 240; m_dir = 0; m_step = 2; m_hold = 0;
      m_aicnt = 0; m_aidir = 0; m_aien_q = 0; m_lim = 0;
      return;
    end
    if (int'(aien) != m_aien_q) begin
      m_aien_q = int'(aien);
      m_dir = 0; m_step = 2; m_hold = 0; m_aicnt = 0; m_aidir = 0;
      m_lim = at_wall(m_y);
      return;
    end
    if (aien) req = m_aidir;
    else if (key == 8'h1A) req = -1;
    else if (key == 8'h16) req = 1;
    else req = 0;

    new_aidir = m_aidir;
    if (m_aicnt == 3) begin
      diff = bally - m_y;
      if (diff <= 4 && diff >= -4) new_aidir = 0;
      else if (diff < 0) new_aidir = -1;
      else new_aidir = 1;
      m_aicnt = 0;
    end else begin
      m_aicnt++;
    end

    if (req == 0) begin
      m_dir = 0; m_step = 2; m_hold = 0;
    end else begin
      if (m_dir != req) begin
        amt = 2; m_step = 2; m_hold = 1;
      end else begin
        amt = m_step;
        m_hold++;
        if (m_hold == 4) begin
          m_hold = 0;
          if (m_step < 8) m_step++;
        end
      end
      m_dir = req;
      m_y = m_y + req * amt;
      if (m_y < 52) m_y = 52;
      if (m_y > 429) m_y = 429;
      if (at_wall(m_y) == 1) begin
        m_step = 2; m_hold = 0;
      end
    end
    m_lim = at_wall(m_y);
    m_aidir = new_aidir;
  endtask

  task automatic frame(input logic rst, input logic [7:0] key, input logic aien, input logic [9:0] bally);
    Reset   = rst;
    keycode = key;
    ai_en   = aien;
    BallY   = bally;
    BallX   = 10'($urandom_range(0, 639));
    @(posedge frame_clk);
    mdl(rst, key, aien, int'(bally));
    #1;
    chk("model_paddle_y", 16'(PaddleY), 16'(m_y));
    chk("model_at_limit", 16'(at_limit), 16'(m_lim));
  endtask

  initial begin
    logic [9:0] track_y;
    logic       r_ai;
    Reset = 1'b1; keycode = 8'h00; ai_en = 1'b0; BallX = '0; BallY = '0;
    m_y = 0; m_dir = 0; m_step = 0; m_hold = 0; m_aicnt = 0; m_aidir = 0; m_aien_q = 0; m_lim = 0;

    // reset and idle
    frame(1'b1, 8'h00, 1'b0, 10'd0);
    frame(1'b1, 8'h00, 1'b0, 10'd0);
    for (int i = 0; i < 3; i++) frame(1'b0, 8'h00, 1'b0, 10'd0);
    chk("rst_paddle_y", 16'(PaddleY), 16'd240);
    chk("rst_paddle_x", 16'(PaddleX), 16'd40);
    chk("rst_paddle_l", 16'(PaddleL), 16'd32);
    chk("rst_paddle_w", 16'(PaddleW), 16'd4);
    chk("rst_at_limit", 16'(at_limit), 16'd0);

    // ramping up
    frame(1'b0, 8'h1A, 1'b0, 10'd0); chk("up_f1", 16'(PaddleY), 16'd238);
    frame(1'b0, 8'h1A, 1'b0, 10'd0); chk("up_f2", 16'(PaddleY), 16'd236);
    frame(1'b0, 8'h1A, 1'b0, 10'd0); chk("up_f3", 16'(PaddleY), 16'd234);
    frame(1'b0, 8'h1A, 1'b0, 10'd0); chk("up_f4", 16'(PaddleY), 16'd232);
    frame(1'b0, 8'h1A, 1'b0, 10'd0); chk("up_f5", 16'(PaddleY), 16'd229);

    // run into the top wall
    for (int i = 0; i < 80 && m_y != 52; i++) frame(1'b0, 8'h1A, 1'b0, 10'd0);
    chk("wall_y", 16'(PaddleY), 16'd52);
    chk("wall_limit", 16'(at_limit), 16'd1);
    frame(1'b0, 8'h1A, 1'b0, 10'd0);
    frame(1'b0, 8'h1A, 1'b0, 10'd0);
    chk("wall_hold_y", 16'(PaddleY), 16'd52);
    frame(1'b0, 8'h00, 1'b0, 10'd0);
    chk("wall_idle_limit", 16'(at_limit), 16'd1);

    // down 6 frames, then immediate reversal, then release with a foreign code
    for (int i = 0; i < 6; i++) frame(1'b0, 8'h16, 1'b0, 10'd0);
    chk("down6_y", 16'(PaddleY), 16'd66);
    frame(1'b0, 8'h1A, 1'b0, 10'd0);
    chk("reverse_y", 16'(PaddleY), 16'd64);
    frame(1'b0, 8'h04, 1'b0, 10'd0);
    chk("other_key_y", 16'(PaddleY), 16'd64);
    chk("other_key_limit", 16'(at_limit), 16'd0);

    // accelerate to step 5, then reset mid-move
    for (int i = 0; i < 12; i++) frame(1'b0, 8'h16, 1'b0, 10'd0);
    chk("accel_y", 16'(PaddleY), 16'd100);
    frame(1'b1, 8'h16, 1'b0, 10'd0);
    chk("midmove_rst_y", 16'(PaddleY), 16'd240);
    chk("midmove_rst_limit", 16'(at_limit), 16'd0);
    frame(1'b0, 8'h16, 1'b0, 10'd0);
    chk("post_rst_down", 16'(PaddleY), 16'd242);
    frame(1'b0, 8'h00, 1'b0, 10'd0);

    // AI chases a ball above the paddle
    frame(1'b0, 8'h00, 1'b1, 10'd100);
    chk("ai_toggle_hold", 16'(PaddleY), 16'd242);
    for (int i = 1; i <= 4; i++) begin
      frame(1'b0, 8'h00, 1'b1, 10'd100);
      chk("ai_wait", 16'(PaddleY), 16'd242);
    end
    frame(1'b0, 8'h00, 1'b1, 10'd100); chk("ai_up1", 16'(PaddleY), 16'd240);
    frame(1'b0, 8'h00, 1'b1, 10'd100); chk("ai_up2", 16'(PaddleY), 16'd238);
    frame(1'b0, 8'h00, 1'b1, 10'd100); chk("ai_up3", 16'(PaddleY), 16'd236);
    track_y = 10'(m_y + 3);
    frame(1'b0, 8'h00, 1'b1, track_y); chk("ai_up4", 16'(PaddleY), 16'd234);
    frame(1'b0, 8'h00, 1'b1, track_y); chk("ai_stop1", 16'(PaddleY), 16'd234);
    frame(1'b0, 8'h00, 1'b1, track_y); chk("ai_stop2", 16'(PaddleY), 16'd234);
    frame(1'b0, 8'h1A, 1'b0, 10'd0);
    chk("ai_off_hold", 16'(PaddleY), 16'd234);

    // random key holds, AI toggles and occasional resets
    r_ai = 1'b0;
    for (int blk = 0; blk < 80; blk++) begin
      logic [7:0] k;
      logic [9:0] by;
      int         len;
      case ($urandom_range(0, 3))
        0:       k = 8'h1A;
        1:       k = 8'h16;
        2:       k = 8'h00;
        default: k = 8'($urandom_range(0, 255));
      endcase
      by  = 10'($urandom_range(0, 479));
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 5) == 0) r_ai = ~r_ai;
      for (int i = 0; i < len; i++) begin
        frame($urandom_range(0, 149) == 0, k, r_ai, by);
      end
    end
    chk("end_paddle_x", 16'(PaddleX), 16'd40);
    chk("end_paddle_l", 16'(PaddleL), 16'd32);
    chk("end_paddle_w", 16'(PaddleW), 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
